// File: rtl/drop_ctrl_if.sv
// Move-request, result and RAM write-port bundle for the drop controller.
// The master side is the requester plus the RAM; the slave side is drop_ctrl.
interface drop_ctrl_if #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     move_valid;
  logic [2:0]               move_col;
  logic                     move_ready;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_we;
  logic                     done_valid;
  logic                     done_ok;
  logic [2:0]               done_row;

  modport slave (
    input  move_valid, move_col,
    output move_ready, mem_addr, mem_wdata, mem_we,
    output done_valid, done_ok, done_row
  );

  modport master (
    output move_valid, move_col,
    input  move_ready, mem_addr, mem_wdata, mem_we,
    input  done_valid, done_ok, done_row
  );
endinterface

// File: rtl/drop_ctrl.sv
// Column-drop move controller: scans the board read-back for the lowest empty
// cell in the requested column, writes the mover's token and alternates turns.
module drop_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ROWS          = 6,
  parameter int unsigned COLS          = 7,
  parameter int unsigned MEM_DEPTH     = ROWS * COLS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  drop_ctrl_if.slave                      bus,
  input  logic [DATA_WIDTH*MEM_DEPTH-1:0] board,
  output logic [1:0]                      cur_player,
  output logic                            board_full
);

  localparam int unsigned POS_W = 3;
  localparam int unsigned CNT_W = $clog2(MEM_DEPTH + 1);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH * MEM_DEPTH);
  localparam logic [1:0]  P1    = 2'd1;
  localparam logic [1:0]  P2    = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state;
  logic [POS_W-1:0]         col;
  logic [POS_W-1:0]         row;
  logic [CNT_W-1:0]         count;

  logic [ADDRESS_WIDTH-1:0] cell_addr_c;
  logic [BIT_W-1:0]         cell_bit_c;
  logic [DATA_WIDTH-1:0]    cell_c;
  logic                     cell_empty_c;
  logic                     last_row_c;
  logic                     bad_col_c;
  logic                     fills_board_c;

  // Cell under examination is selected from the flat read-back each cycle.
  always_comb begin
    cell_addr_c   = ADDRESS_WIDTH'(row) * ADDRESS_WIDTH'(COLS) + ADDRESS_WIDTH'(col);
    cell_bit_c    = BIT_W'(cell_addr_c) * BIT_W'(DATA_WIDTH);
    cell_c        = DATA_WIDTH'(board >> cell_bit_c);
    cell_empty_c  = (cell_c == '0);
    last_row_c    = (32'(row) == ROWS - 1);
    bad_col_c     = (32'(bus.move_col) >= COLS);
    fills_board_c = bus.done_ok && (32'(count) == MEM_DEPTH - 1);
  end

  // Move sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      col            <= '0;
      row            <= '0;
      count          <= '0;
      cur_player     <= P1;
      board_full     <= 1'b0;
      bus.move_ready <= 1'b1;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.done_valid <= 1'b0;
      bus.done_ok    <= 1'b0;
      bus.done_row   <= '0;
    end else begin
      bus.mem_we     <= 1'b0;
      bus.done_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.move_valid && bus.move_ready) begin
            col            <= bus.move_col;
            row            <= '0;
            bus.move_ready <= 1'b0;
            if (bad_col_c) begin
              state          <= DONE;
              bus.done_valid <= 1'b1;
              bus.done_ok    <= 1'b0;
              bus.done_row   <= '0;
            end else begin
              state <= SCAN;
            end
          end
        end

        SCAN: begin
          if (cell_empty_c) begin
            state         <= WRITE;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= cell_addr_c;
            bus.mem_wdata <= DATA_WIDTH'(cur_player);
          end else if (last_row_c) begin
            state          <= DONE;
            bus.done_valid <= 1'b1;
            bus.done_ok    <= 1'b0;
            bus.done_row   <= '0;
          end else begin
            row <= row + POS_W'(1);
          end
        end

        WRITE: begin
          state          <= DONE;
          bus.done_valid <= 1'b1;
          bus.done_ok    <= 1'b1;
          bus.done_row   <= row;
        end

        DONE: begin
          state <= IDLE;
          // Turn and fill count advance only on a placed token.
          if (bus.done_ok) begin
            cur_player <= (cur_player == P1) ? P2 : P1;
            count      <= count + CNT_W'(1);
          end
          if (fills_board_c) begin
            board_full <= 1'b1;
          end
          bus.move_ready <= ~(board_full | fills_board_c);
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drop_ctrl.sv
// Scoreboard bench for drop_ctrl: a bench-owned RAM feeds the board read-back,
// a height model predicts writes and results, and a monitor pops on each event.
module tb_drop_ctrl;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned ROWS  = 6;
  localparam int unsigned COLS  = 7;
  localparam int unsigned DEPTH = ROWS * COLS;

  typedef struct {
    logic       ok;
    logic [2:0] row;
    int         lat;
  } done_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            lat;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ram_clr;
  logic [DW*DEPTH-1:0] board;
  logic [1:0]        cur_player;
  logic              board_full;
  logic [DW-1:0]     ram [DEPTH];

  done_t done_q[$];
  wr_t   wr_q[$];

  int cyc = 0;
  int acc_cyc = 0;
  int checks = 0;
  int errors = 0;
  int height [COLS];
  int player;

  always #5 clk = ~clk;

  drop_ctrl_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  drop_ctrl #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .ROWS         (ROWS),
    .COLS         (COLS),
    .MEM_DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .board      (board),
    .cur_player (cur_player),
    .board_full (board_full)
  );

  for (genvar j = 0; j < DEPTH; j++) begin : g_board
    assign board[j*DW +: DW] = ram[j];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_clr) begin
      for (int j = 0; j < DEPTH; j++) ram[j] <= '0;
    end else if (bus.mem_we && (bus.mem_addr < AW'(DEPTH))) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Latency is counted in cycles with the accepting cycle as cycle 1.
  always @(negedge clk) begin : monitor
    wr_t   w;
    done_t d;
    if (rst_n) begin
      if (bus.mem_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_we", 32'd1, 32'd0);
        end else begin
          w = wr_q.pop_front();
          check("we_addr", 32'(bus.mem_addr), 32'(w.addr));
          check("we_data", bus.mem_wdata, w.data);
          check("we_lat", 32'(cyc - acc_cyc + 1), 32'(w.lat));
        end
      end
      if (bus.done_valid) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          d = done_q.pop_front();
          check("done_ok", 32'(bus.done_ok), 32'(d.ok));
          check("done_row", 32'(bus.done_row), 32'(d.row));
          check("done_lat", 32'(cyc - acc_cyc + 1), 32'(d.lat));
        end
      end
    end
  end

  task automatic wait_accept();
    int n = 0;
    while (!bus.move_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(bus.move_ready), 32'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.move_valid = 1'b0;
  endtask

  task automatic drop(input int c, input bit poke);
    int r;
    int n;
    @(negedge clk);
    if (c >= COLS) begin
      done_q.push_back('{ok: 1'b0, row: 3'd0, lat: 1});
    end else if (height[c] == ROWS) begin
      done_q.push_back('{ok: 1'b0, row: 3'd0, lat: 7});
    end else begin
      r = height[c];
      wr_q.push_back('{addr: AW'(r * COLS + c), data: DW'(player), lat: r + 2});
      done_q.push_back('{ok: 1'b1, row: 3'(r), lat: r + 3});
      height[c]++;
      player = (player == 1) ? 2 : 1;
    end
    bus.move_valid = 1'b1;
    bus.move_col   = 3'(c);
    wait_accept();
    if (poke) begin
      @(negedge clk);
      check("busy_ready", 32'(bus.move_ready), 32'd0);
      bus.move_valid = 1'b1;
      bus.move_col   = 3'd1;
      @(negedge clk);
      bus.move_valid = 1'b0;
    end
    n = 0;
    while ((done_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (done_q.size() != 0) begin
      check("done_timeout", 32'd1, 32'd0);
      done_q.delete();
      wr_q.delete();
    end
    repeat (3) @(negedge clk);
    check("cur_player", 32'(cur_player), 32'(player));
  endtask

  task automatic apply_reset(input bit clear_ram);
    @(negedge clk);
    rst_n   = 1'b0;
    ram_clr = clear_ram;
    #1;
    check("rst_ready", 32'(bus.move_ready), 32'd1);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_done", 32'(bus.done_valid), 32'd0);
    check("rst_player", 32'(cur_player), 32'd1);
    check("rst_full", 32'(board_full), 32'd0);
    done_q.delete();
    wr_q.delete();
    player = 1;
    if (clear_ram) begin
      for (int c = 0; c < COLS; c++) height[c] = 0;
    end
    repeat (2) @(negedge clk);
    ram_clr = 1'b0;
    rst_n   = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    ram_clr        = 1'b1;
    bus.move_valid = 1'b0;
    bus.move_col   = 3'd0;
    player         = 1;
    for (int c = 0; c < COLS; c++) height[c] = 0;
    #2;
    check("reset_addr", 32'(bus.mem_addr), 32'd0);
    check("reset_wdata", bus.mem_wdata, 32'd0);
    check("reset_done_ok", 32'(bus.done_ok), 32'd0);
    check("reset_done_row", 32'(bus.done_row), 32'd0);
    apply_reset(1'b1);

    // Empty board, then a stacked column.
    drop(3, 1'b0);
    drop(3, 1'b0);
    drop(3, 1'b0);

    // Fill column 0 and overflow it.
    for (int i = 0; i < ROWS; i++) drop(0, 1'b0);
    drop(0, 1'b0);

    // Out-of-range column, then a busy-time request pulse.
    drop(7, 1'b0);
    drop(3, 1'b1);

    // Reset during the scan of a row-4 drop: nothing is written or reported.
    for (int i = 0; i < 4; i++) drop(5, 1'b0);
    @(negedge clk);
    bus.move_valid = 1'b1;
    bus.move_col   = 3'd5;
    wait_accept();
    repeat (2) @(negedge clk);
    apply_reset(1'b0);
    repeat (10) @(negedge clk);
    drop(5, 1'b0);

    // Fill the whole board from a cleared RAM.
    apply_reset(1'b1);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) drop(c, 1'b0);
    end
    check("full_flag", 32'(board_full), 32'd1);
    check("full_ready", 32'(bus.move_ready), 32'd0);
    bus.move_valid = 1'b1;
    bus.move_col   = 3'd2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("full_hold_ready", 32'(bus.move_ready), 32'd0);
    end
    bus.move_valid = 1'b0;
    check("full_stays", 32'(board_full), 32'd1);
    check("full_no_pending", 32'(done_q.size() + wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
